// File: rtl/wave_capture_if.sv
// Interface bundling the audio sample stream, the display idle flag and the
// display RAM write port of the wave_capture block.
//   master : the capture engine (drives RAM writes and read_index)
//   slave  : the surrounding system (drives samples and display idle)
interface wave_capture_if #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 8
);

  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [ADDR_W:0]     write_address;
  logic                write_enable;
  logic [7:0]          write_sample;
  logic                read_index;

  modport master (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index
  );

  modport slave (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index
  );

endinterface

// File: rtl/wave_capture.sv
// wave_capture: triggers on a positive zero crossing of the audio stream,
// fills the back half of a double-buffered 512x8 display RAM with one
// screen of offset-binary samples, then flips read_index once the display
// is idle so the fresh half becomes visible.
//
// Build option: define WAVE_CAPTURE_DECIM_EN to keep only one sample in
// every 2^DECIM_LOG2 while capturing (one screen then spans more time).
// Without it every captured strobe is written and DECIM_LOG2 has no effect.
module wave_capture #(
  parameter int SAMPLE_W   = 16,
  parameter int ADDR_W     = 8,
  parameter int DECIM_LOG2 = 1
) (
  input  logic           clk,
  input  logic           reset,   // asynchronous, active low
  wave_capture_if.master bus
);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_WAIT   = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] COUNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] COUNT_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] COUNT_ONE  = ADDR_W'(1'b1);

  // Signed sample -> offset binary: flip the sign bit, keep the top byte.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] top_byte);
    return {~top_byte[7], top_byte[6:0]};
  endfunction

  state_t            state_r;
  logic [ADDR_W-1:0] count_r;
  logic              prev_msb_r;   // sign of the previous sample is all the trigger needs
  logic              read_index_r;
  logic              write_enable_r;
  logic [ADDR_W:0]   write_address_r;
  logic [7:0]        write_sample_r;

  logic              strobe_s;
  logic              crossing_s;
  logic              last_slot_s;
  logic              write_slot_s;
  logic [7:0]        converted_s;
  logic              unused_sample_bits_s;

  // Only the top byte of a sample reaches the RAM; the rest is dropped.
  assign unused_sample_bits_s = ^bus.new_sample_in[SAMPLE_W-9:0];

`ifdef WAVE_CAPTURE_DECIM_EN
  localparam logic [DECIM_LOG2-1:0] DECIM_ZERO = {DECIM_LOG2{1'b0}};
  localparam logic [DECIM_LOG2-1:0] DECIM_ONE  = DECIM_LOG2'(1'b1);

  logic [DECIM_LOG2-1:0] decim_r;

  // Strobe counter inside a capture; a sample is kept only when it reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      decim_r <= DECIM_ZERO;
    end else if (state_r == ST_ARMED) begin
      decim_r <= DECIM_ZERO;
    end else if ((state_r == ST_ACTIVE) && strobe_s) begin
      decim_r <= decim_r + DECIM_ONE;
    end else begin
      decim_r <= decim_r;
    end
  end
`else
  // DECIM_LOG2 is meaningful only when decimation is built in.
  if (DECIM_LOG2 < 0) begin : g_decim_unused
  end
`endif

  // Trigger, slot selection and data conversion for the current strobe.
  always_comb begin
    strobe_s     = bus.new_sample_ready;
    crossing_s   = 1'b0;
    last_slot_s  = 1'b0;
    write_slot_s = 1'b0;
    converted_s  = to_offset_binary(bus.new_sample_in[SAMPLE_W-1 -: 8]);
    if (prev_msb_r && !bus.new_sample_in[SAMPLE_W-1]) begin
      crossing_s = 1'b1;
    end else begin
      crossing_s = 1'b0;
    end
    if (count_r == COUNT_LAST) begin
      last_slot_s = 1'b1;
    end else begin
      last_slot_s = 1'b0;
    end
`ifdef WAVE_CAPTURE_DECIM_EN
    if (decim_r == DECIM_ZERO) begin
      write_slot_s = 1'b1;
    end else begin
      write_slot_s = 1'b0;
    end
`else
    write_slot_s = 1'b1;
`endif
  end

  // Capture FSM with registered RAM write port and buffer flip.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_ARMED;
      count_r         <= COUNT_ZERO;
      prev_msb_r      <= 1'b0;
      read_index_r    <= 1'b0;
      write_enable_r  <= 1'b0;
      write_address_r <= {(ADDR_W+1){1'b0}};
      write_sample_r  <= 8'h00;
    end else begin
      write_enable_r <= 1'b0;
      if (strobe_s) begin
        prev_msb_r <= bus.new_sample_in[SAMPLE_W-1];
      end
      case (state_r)
        ST_ARMED: begin
          // The crossing sample only arms the capture; it is not stored.
          if (strobe_s && crossing_s) begin
            state_r <= ST_ACTIVE;
            count_r <= COUNT_ZERO;
          end
        end
        ST_ACTIVE: begin
          if (strobe_s && write_slot_s) begin
            write_enable_r  <= 1'b1;
            write_address_r <= {~read_index_r, count_r};
            write_sample_r  <= converted_s;
            if (last_slot_s) begin
              state_r <= ST_WAIT;
              count_r <= COUNT_ZERO;
            end else begin
              count_r <= count_r + COUNT_ONE;
            end
          end
        end
        ST_WAIT: begin
          // Flip only while the display is outside its active region.
          if (bus.wave_display_idle) begin
            read_index_r <= ~read_index_r;
            state_r      <= ST_ARMED;
          end
        end
        default: begin
          state_r <= ST_ARMED;
          count_r <= COUNT_ZERO;
        end
      endcase
    end
  end

  assign bus.write_enable  = write_enable_r;
  assign bus.write_address = write_address_r;
  assign bus.write_sample  = write_sample_r;
  assign bus.read_index    = read_index_r;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture.
module tb_wave_capture;

`ifdef WAVE_CAPTURE_DECIM_EN
  localparam int DL = 1;
`else
  localparam int DL = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  wave_capture_if #(.SAMPLE_W(16), .ADDR_W(8)) bus ();

  wave_capture #(.SAMPLE_W(16), .ADDR_W(8), .DECIM_LOG2(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns 1 time unit after the edge that samples it.
  task automatic send(input logic [15:0] s);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = s;
    @(posedge clk);
    #1;
    bus.new_sample_ready = 1'b0;
  endtask

  task automatic send_no_write(input string tag, input logic [15:0] s);
    send(s);
    chk(tag, {31'd0, bus.write_enable}, 32'd0);
  endtask

  // Ramp capture: written entry k carries sample k<<8, i.e. data k^0x80.
  task automatic run_capture(input int n_writes, input logic half);
    for (int i = 0; i < (n_writes << DL); i++) begin
      logic [7:0] k;
      k = 8'(i >> DL);
      send({k, 8'h00});
      if ((i & ((1 << DL) - 1)) == 0) begin
        chk($sformatf("cap_h%0d_i%0d", half, i),
            {14'd0, bus.write_enable, bus.write_address, bus.write_sample},
            {14'd0, 1'b1, half, k, k ^ 8'h80});
      end else begin
        chk($sformatf("skip_h%0d_i%0d", half, i), {31'd0, bus.write_enable}, 32'd0);
      end
    end
  endtask

  task automatic idle_pulse();
    bus.wave_display_idle = 1'b1;
    @(posedge clk);
    #1;
    bus.wave_display_idle = 1'b0;
  endtask

  initial begin
    reset                 = 1'b0;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = 16'h0000;
    bus.wave_display_idle = 1'b0;

    // Reset state
    #3;
    chk("rst_outputs", {13'd0, bus.write_enable, bus.write_address, bus.write_sample, bus.read_index}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_quiet", {13'd0, bus.write_enable, bus.write_address, bus.write_sample, bus.read_index}, 32'd0);

    // Rising input with no preceding negative sample never triggers
    send_no_write("rise0", 16'h0000);
    send_no_write("rise1", 16'h1000);
    send_no_write("rise2", 16'h2000);
    send_no_write("rise3", 16'h7FFF);

    // -5 then +3 triggers; the +3 itself is not written
    send_no_write("neg5", 16'hFFFB);
    send_no_write("trig_pos3", 16'h0003);
    run_capture(256, 1'b1);
    @(posedge clk);
    #1;
    chk("no_extra_we", {31'd0, bus.write_enable}, 32'd0);
    chk("ri_before_flip", {31'd0, bus.read_index}, 32'd0);

    // WAIT ignores strobes while the display is busy
    for (int i = 0; i < 50; i++) begin
      send_no_write($sformatf("wait_strobe%0d", i), 16'h0500);
    end
    chk("ri_held_in_wait", {31'd0, bus.read_index}, 32'd0);

    // Idle and strobe on the same edge: one flip, no write
    bus.wave_display_idle = 1'b1;
    send(16'h8001);
    bus.wave_display_idle = 1'b0;
    chk("flip_we", {31'd0, bus.write_enable}, 32'd0);
    chk("flip_ri", {31'd0, bus.read_index}, 32'd1);

    // The WAIT-era negative sample is the prev for this trigger
    send_no_write("trig_after_flip", 16'h0010);
    run_capture(256, 1'b0);
    idle_pulse();
    chk("flip2_ri", {31'd0, bus.read_index}, 32'd0);

    send_no_write("neg_c3", 16'hFFFF);
    send_no_write("trig_c3", 16'h0001);
    run_capture(256, 1'b1);
    idle_pulse();
    chk("flip3_ri", {31'd0, bus.read_index}, 32'd1);

    // Reset at count 100 in ACTIVE
    send_no_write("neg_c4", 16'h8000);
    send_no_write("trig_c4", 16'h0000);
    run_capture(100, 1'b0);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = 16'h1234;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_async", {13'd0, bus.write_enable, bus.write_address, bus.write_sample, bus.read_index}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_held", {13'd0, bus.write_enable, bus.write_address, bus.write_sample, bus.read_index}, 32'd0);
    bus.new_sample_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_no_write("post_rst_pos1", 16'h0100);
    send_no_write("post_rst_pos2", 16'h0200);
    send_no_write("post_rst_neg", 16'hC000);
    send_no_write("post_rst_trig", 16'h2000);
    send(16'h7FFF);
    chk("post_rst_first_write",
        {14'd0, bus.write_enable, bus.write_address, bus.write_sample},
        {14'd0, 1'b1, 9'h100, 8'hFF});
    chk("post_rst_ri", {31'd0, bus.read_index}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
